// File: rtl/turn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : turn_pkg
// Brief   : Shared FSM state type, default play-state code and popcount helper
//           for the turn arbiter and the top-level game FSM.
// Revision: 1.0 - initial release
// ============================================================================
package turn_pkg;

    localparam int unsigned C_MAX_PLAYERS = 8;

    // Game-state code in which players take turns; the game FSM uses the same value.
    localparam logic [2:0] C_PLAY_STATE_DEFAULT = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TURN    = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } turn_state_t;

    function automatic logic [3:0] popcount8(input logic [C_MAX_PLAYERS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < int'(C_MAX_PLAYERS); i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/next_alive_sel.sv
`default_nettype none
// ============================================================================
// Module  : next_alive_sel
// Brief   : Combinational round-robin search for the first alive player after
//           cur_idx (cur_idx itself is the last candidate).
// Revision: 1.0 - initial release
// ============================================================================
module next_alive_sel
#(
    parameter int NUM_PLAYERS = 2
)(
    input  logic [$clog2(NUM_PLAYERS)-1:0] cur_idx,
    input  logic [NUM_PLAYERS-1:0]         alive,
    output logic [$clog2(NUM_PLAYERS)-1:0] next_idx,
    output logic                           none_left
);

    localparam int PW = $clog2(NUM_PLAYERS);

    // Walk from the farthest candidate to the nearest so the nearest alive one wins.
    always_comb begin
        int w_idx;
        next_idx  = cur_idx;
        none_left = 1'b1;
        w_idx     = 0;
        for (int k = NUM_PLAYERS; k >= 1; k--) begin
            w_idx = (int'(cur_idx) + k) % NUM_PLAYERS;
            if (alive[w_idx]) begin
                next_idx  = PW'(w_idx);
                none_left = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/turn_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : turn_arbiter
// Brief   : Round-robin fire-permission arbiter for NUM_PLAYERS players with
//           elimination skipping, turn timeout and game-over detection.
// Revision: 1.0 - initial release
// ============================================================================
module turn_arbiter
    import turn_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int STATE_W        = 3,
    parameter int PLAY_STATE     = int'(C_PLAY_STATE_DEFAULT),
    parameter int TIMEOUT_CYCLES = 0
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [STATE_W-1:0]             state,
    input  logic [NUM_PLAYERS-1:0]         player_alive,
    input  logic [NUM_PLAYERS-1:0]         fire_req,
    input  logic                           shot_done,
    output logic [NUM_PLAYERS-1:0]         fire_en,
    output logic [NUM_PLAYERS-1:0]         fire_grant,
    output logic [$clog2(NUM_PLAYERS)-1:0] active_player,
    output logic                           taking_turns,
    output logic                           turn_timeout,
    output logic                           game_over
);

    localparam int PW = $clog2(NUM_PLAYERS);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    turn_state_t            r_state;
    logic [NUM_PLAYERS-1:0] r_fire_en;
    logic [NUM_PLAYERS-1:0] r_fire_grant;
    logic [PW-1:0]          r_active;
    logic                   r_taking_turns;
    logic                   r_turn_timeout;
    logic                   r_game_over;

    logic                   w_play;
    logic                   w_few_alive;
    logic                   w_req;
    logic                   w_alive_cur;
    logic                   w_expire;
    logic                   w_advance;
    logic                   w_end_game;
    logic [PW-1:0]          w_sel_cur;
    logic [PW-1:0]          w_next;
    logic                   w_none_left;
    logic [NUM_PLAYERS-1:0] w_next_onehot;

    assign w_play      = (state == STATE_W'(PLAY_STATE));
    assign w_few_alive = (popcount8(C_MAX_PLAYERS'(player_alive)) <= 4'd1);
    assign w_req       = fire_req[r_active];
    assign w_alive_cur = player_alive[r_active];

    // Outside a game the search starts just before index 0, yielding the lowest alive player.
    assign w_sel_cur = (r_state == ST_TURN || r_state == ST_RESOLVE) ? r_active
                                                                     : PW'(NUM_PLAYERS - 1);

    next_alive_sel #(
        .NUM_PLAYERS (NUM_PLAYERS)
    ) u_next_alive_sel (
        .cur_idx   (w_sel_cur),
        .alive     (player_alive),
        .next_idx  (w_next),
        .none_left (w_none_left)
    );

    assign w_next_onehot = {{(NUM_PLAYERS-1){1'b0}}, 1'b1} << w_next;
    assign w_end_game    = w_few_alive | w_none_left;

    assign w_advance = w_play &&
                       (((r_state == ST_TURN) && (!w_alive_cur || (!w_req && w_expire))) ||
                        ((r_state == ST_RESOLVE) && shot_done));

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            logic [TW-1:0] r_count;
            logic          w_hold;

            // Counter survives only while the same player keeps an uneventful turn.
            assign w_hold   = (r_state == ST_TURN) && w_play && w_alive_cur && !w_req && !w_expire;
            assign w_expire = (r_count == TW'(TIMEOUT_CYCLES - 1));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_count <= '0;
                end else if (w_hold) begin
                    r_count <= r_count + TW'(1);
                end else begin
                    r_count <= '0;
                end
            end
        end else begin : g_no_timeout
            assign w_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_fire_en      <= '0;
            r_fire_grant   <= '0;
            r_active       <= '0;
            r_taking_turns <= 1'b0;
            r_turn_timeout <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_fire_grant   <= '0;
            r_turn_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_play && !w_few_alive) begin
                        r_state        <= ST_TURN;
                        r_active       <= w_next;
                        r_fire_en      <= w_next_onehot;
                        r_taking_turns <= 1'b1;
                    end
                end
                ST_TURN, ST_RESOLVE: begin
                    if (!w_play) begin
                        r_state        <= ST_IDLE;
                        r_fire_en      <= '0;
                        r_active       <= '0;
                        r_taking_turns <= 1'b0;
                    end else if (w_advance) begin
                        r_turn_timeout <= (r_state == ST_TURN) && w_alive_cur;
                        if (w_end_game) begin
                            r_state        <= ST_DONE;
                            r_fire_en      <= '0;
                            r_taking_turns <= 1'b0;
                            r_game_over    <= 1'b1;
                        end else begin
                            r_state   <= ST_TURN;
                            r_active  <= w_next;
                            r_fire_en <= w_next_onehot;
                        end
                    end else if (r_state == ST_TURN && w_req) begin
                        r_state      <= ST_RESOLVE;
                        r_fire_grant <= r_fire_en;
                        r_fire_en    <= '0;
                    end
                end
                ST_DONE: begin
                    if (!w_play) begin
                        r_state     <= ST_IDLE;
                        r_active    <= '0;
                        r_game_over <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fire_en       = r_fire_en;
    assign fire_grant    = r_fire_grant;
    assign active_player = r_active;
    assign taking_turns  = r_taking_turns;
    assign turn_timeout  = r_turn_timeout;
    assign game_over     = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_turn_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_turn_arbiter
// Brief   : Directed scoreboard bench for turn_arbiter (4 players, timeout 5).
// Revision: 1.0 - initial release
// ============================================================================
module tb_turn_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] state;
    logic [3:0] player_alive;
    logic [3:0] fire_req;
    logic       shot_done;
    logic [3:0] fire_en;
    logic [3:0] fire_grant;
    logic [1:0] active_player;
    logic       taking_turns;
    logic       turn_timeout;
    logic       game_over;

    turn_arbiter #(
        .NUM_PLAYERS    (4),
        .STATE_W        (3),
        .PLAY_STATE     (3),
        .TIMEOUT_CYCLES (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .state         (state),
        .player_alive  (player_alive),
        .fire_req      (fire_req),
        .shot_done     (shot_done),
        .fire_en       (fire_en),
        .fire_grant    (fire_grant),
        .active_player (active_player),
        .taking_turns  (taking_turns),
        .turn_timeout  (turn_timeout),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       cyc;
        logic [3:0] en;
        logic [3:0] gr;
        logic [1:0] ap;
        bit         apc;
        logic       tt;
        logic       to;
        logic       go;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [12:0] obs;
    logic [12:0] prev = '0;

    assign obs = {fire_en, fire_grant, active_player, taking_turns, turn_timeout, game_over};

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected output vector, appearing dc cycles after the current negedge.
    task automatic exp(input int dc, input logic [3:0] en, input logic [3:0] gr,
                       input logic [1:0] ap, input bit apc,
                       input logic tt, input logic to, input logic go);
        exp_t e;
        e.cyc = cyc + dc; e.en = en; e.gr = gr; e.ap = ap; e.apc = apc;
        e.tt = tt; e.to = to; e.go = go;
        q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if (obs !== 13'd0) begin
            n_err++;
            $display("FAIL %s: outputs got %b want all zero", name, obs);
        end
    endtask

    // Monitor: every change of the output vector must match the next expectation.
    always @(negedge clk) begin
        if (reset) begin
            prev = obs;
        end else if (obs !== prev) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected change cyc=%0d: got en=%b gr=%b ap=%0d tt=%b to=%b go=%b",
                         cyc, fire_en, fire_grant, active_player, taking_turns, turn_timeout, game_over);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc || fire_en !== e.en || fire_grant !== e.gr ||
                    (e.apc && active_player !== e.ap) || taking_turns !== e.tt ||
                    turn_timeout !== e.to || game_over !== e.go) begin
                    n_err++;
                    $display("FAIL vector cyc=%0d: got en=%b gr=%b ap=%0d tt=%b to=%b go=%b; want cyc=%0d en=%b gr=%b ap=%0d tt=%b to=%b go=%b",
                             cyc, fire_en, fire_grant, active_player, taking_turns, turn_timeout, game_over,
                             e.cyc, e.en, e.gr, e.ap, e.tt, e.to, e.go);
                end
            end
            prev = obs;
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing change cyc=%0d: got en=%b gr=%b ap=%0d to=%b go=%b; want en=%b gr=%b ap=%0d to=%b go=%b",
                     cyc, fire_en, fire_grant, active_player, turn_timeout, game_over,
                     e.en, e.gr, e.ap, e.to, e.go);
        end
    end

    initial begin
        reset        = 1'b1;
        state        = 3'd0;
        player_alive = 4'b0011;
        fire_req     = 4'b0000;
        shot_done    = 1'b0;
        repeat (2) tick();
        check_zero("reset_values");
        reset = 1'b0;
        tick();

        // Two alive players: first turn, grant, resolve, hand-over
        state = 3'd3;                  exp(1, 4'b0001, 4'b0000, 2'd0, 1, 1, 0, 0);
        tick(); fire_req = 4'b0001;    exp(1, 4'b0000, 4'b0001, 2'd0, 1, 1, 0, 0);
        tick(); fire_req = 4'b0000;    exp(1, 4'b0000, 4'b0000, 2'd0, 1, 1, 0, 0);
        tick(); shot_done = 1'b1;      exp(1, 4'b0010, 4'b0000, 2'd1, 1, 1, 0, 0);
        tick(); shot_done = 1'b0; fire_req = 4'b0001;       // non-active request ignored
        tick(); fire_req = 4'b0010;    exp(1, 4'b0000, 4'b0010, 2'd1, 1, 1, 0, 0);
        tick(); fire_req = 4'b0000;    exp(1, 4'b0000, 4'b0000, 2'd1, 1, 1, 0, 0);
        tick(); shot_done = 1'b1;      exp(1, 4'b0001, 4'b0000, 2'd0, 1, 1, 0, 0);

        // p0 idles: p1 requests meanwhile, stray shot_done, then timeout after 5 cycles
        tick(); shot_done = 1'b0; fire_req = 4'b0010;
        exp(5, 4'b0010, 4'b0000, 2'd1, 1, 1, 1, 0);
        exp(6, 4'b0010, 4'b0000, 2'd1, 1, 1, 0, 0);
        tick(); shot_done = 1'b1;
        tick(); shot_done = 1'b0; fire_req = 4'b0000;
        repeat (7) tick();

        // Request on the expiry edge wins over the timeout
        fire_req = 4'b0010;            exp(1, 4'b0000, 4'b0010, 2'd1, 1, 1, 0, 0);
        tick(); fire_req = 4'b0000;    exp(1, 4'b0000, 4'b0000, 2'd1, 1, 1, 0, 0);

        // Long RESOLVE (no timeout), then rotation with alive=1011: 1 -> 3 -> 0 -> 1
        tick(); player_alive = 4'b1011;
        repeat (6) tick();
        shot_done = 1'b1;              exp(1, 4'b1000, 4'b0000, 2'd3, 1, 1, 0, 0);
        tick(); shot_done = 1'b0; fire_req = 4'b1000;
                                       exp(1, 4'b0000, 4'b1000, 2'd3, 1, 1, 0, 0);
        tick(); fire_req = 4'b0000; shot_done = 1'b1;
                                       exp(1, 4'b0001, 4'b0000, 2'd0, 1, 1, 0, 0);
        tick(); shot_done = 1'b0; fire_req = 4'b0001;
                                       exp(1, 4'b0000, 4'b0001, 2'd0, 1, 1, 0, 0);
        tick(); fire_req = 4'b0000;    exp(1, 4'b0000, 4'b0000, 2'd0, 1, 1, 0, 0);
        tick(); shot_done = 1'b1;      exp(1, 4'b0010, 4'b0000, 2'd1, 1, 1, 0, 0);

        // Active player eliminated during TURN: silent advance to p3
        tick(); shot_done = 1'b0; player_alive = 4'b1001;
                                       exp(1, 4'b1000, 4'b0000, 2'd3, 1, 1, 0, 0);
        tick(); fire_req = 4'b1000;    exp(1, 4'b0000, 4'b1000, 2'd3, 1, 1, 0, 0);

        // Down to one player during RESOLVE: game over, then back to IDLE
        tick(); fire_req = 4'b0000; player_alive = 4'b0001;
                                       exp(1, 4'b0000, 4'b0000, 2'd3, 1, 1, 0, 0);
        tick(); shot_done = 1'b1;      exp(1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, 1);
        tick(); shot_done = 1'b0;
        repeat (2) tick();
        state = 3'd0;                  exp(1, 4'b0000, 4'b0000, 2'd0, 1, 0, 0, 0);

        // Start from lowest alive (p1), abort with a pending request, restart at p0
        tick(); state = 3'd3; player_alive = 4'b0110;
                                       exp(1, 4'b0010, 4'b0000, 2'd1, 1, 1, 0, 0);
        tick(); state = 3'd4; fire_req = 4'b0010;
                                       exp(1, 4'b0000, 4'b0000, 2'd0, 1, 0, 0, 0);
        tick(); state = 3'd3; fire_req = 4'b0000; player_alive = 4'b0111;
                                       exp(1, 4'b0001, 4'b0000, 2'd0, 1, 1, 0, 0);
        tick(); fire_req = 4'b0001;    exp(1, 4'b0000, 4'b0001, 2'd0, 1, 1, 0, 0);
        tick(); fire_req = 4'b0000;    exp(1, 4'b0000, 4'b0000, 2'd0, 1, 1, 0, 0);

        // Asynchronous reset while in RESOLVE
        tick();
        #2 reset = 1'b1; player_alive = 4'b0001;
        #1 check_zero("async_reset_in_resolve");
        repeat (2) tick();
        reset = 1'b0;

        // One alive player: PLAY state must not start a game
        repeat (5) tick();

        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL pending_expectations: got %0d left want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/turn_arbiter.md
# turn_arbiter

Parametrised successor to the two-player fire-permission logic. It grants fire permission to exactly one of NUM_PLAYERS players at a time, in round-robin order, while the top-level game FSM is in its play state. It skips eliminated players, forfeits a turn on timeout and flags game over when one or fewer players remain alive. It sits between the game-state FSM and the per-player shot/board logic.

## Interface
- NUM_PLAYERS, 2: number of players, 2..8
- STATE_W, 3: width of the game-state input
- PLAY_STATE, 3: game-state encoding in which turns are taken
- TIMEOUT_CYCLES, 0: cycles a player may idle before forfeiting; 0 disables the timeout
- PW, $clog2(NUM_PLAYERS): width of the player index (derived localparam)

Ports:
- clk  in  1  system clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- state  in  STATE_W  current game state from the top-level FSM
- player_alive  in  NUM_PLAYERS  bit i set means player i is still in the game
- fire_req  in  NUM_PLAYERS  per-player fire request (level)
- shot_done  in  1  one-cycle pulse from the board logic when the granted shot is resolved
- fire_en  out  NUM_PLAYERS  one-hot, registered; the active player may fire
- fire_grant  out  NUM_PLAYERS  one-hot, one-cycle pulse; the shot is accepted
- active_player  out  PW  index of the player whose turn it is
- taking_turns  out  1  high in the TURN and RESOLVE states
- turn_timeout  out  1  one-cycle pulse when a turn is forfeited
- game_over  out  1  high in the DONE state

## Operation
- FSM states:
  - IDLE: all outputs low.
  - IDLE -> TURN when state==PLAY_STATE and popcount(player_alive)>=2. active_player becomes the lowest-index alive player.
  - TURN: fire_en[active_player] is high.
    - fire_req[active_player]=1 -> fire_grant pulses, fire_en drops, go to RESOLVE.
    - Timeout expiry -> turn_timeout pulses, advance to the next player, stay in TURN.
  - RESOLVE: wait for shot_done. Then advance to the next player and return to TURN. The timeout does not run in RESOLVE.
  - DONE: game_over=1. Exit to IDLE only when state != PLAY_STATE.
- Next player: the first alive index after active_player, cyclically, with wrap from NUM_PLAYERS-1 to 0. Alive status is re-evaluated at each advance.
- At every advance, if popcount(player_alive)<=1, go to DONE instead of TURN.
- fire_req from non-active players is ignored in every state. fire_req from the active player is ignored in RESOLVE.
- If the active player's alive bit clears during TURN, advance on the next edge as if timed out, but without pulsing turn_timeout.
- state != PLAY_STATE in TURN or RESOLVE aborts to IDLE on the next edge. fire_en clears and no grant is issued.
- Timeout counter:
  - PW-independent width, $clog2(TIMEOUT_CYCLES+1).
  - Cleared on every entry to TURN; increments each TURN cycle.
  - Expires when it reaches TIMEOUT_CYCLES-1 with no request.

## Timing
- All outputs are registered. Reset values: fire_en=0, fire_grant=0, active_player=0, taking_turns=0, turn_timeout=0, game_over=0, FSM=IDLE.
- Edge E samples state==PLAY_STATE in IDLE -> fire_en is valid in cycle E+1.
- fire_req sampled at edge N -> fire_grant pulses during cycle N+1, and fire_en is low in that same cycle.
- shot_done at edge M -> the new active_player and fire_en are valid in cycle M+1.
- Timeout: if fire_en went high at edge T, turn_timeout pulses in cycle T+TIMEOUT_CYCLES and the next player's fire_en is valid in that same cycle.
- fire_req on the expiry edge: the request wins; no timeout is issued.
- shot_done outside RESOLVE is ignored.
- Reset mid-turn returns to the reset values immediately (asynchronous).

## Structure
- Shared package turn_pkg holds:
  - the FSM state typedef (IDLE, TURN, RESOLVE, DONE);
  - the default PLAY_STATE constant, shared with the game FSM.
- Sub-module next_alive_sel: combinational round-robin search. Inputs are the current index and the alive mask; outputs are the next index and a `none_left` flag. It is instantiated once.

## Test plan
- Defaults, state=3 after reset: p0 fire_en=1. fire_req[0] -> grant 01 one cycle later. shot_done -> fire_en=10, active_player=1.
- NUM_PLAYERS=4, alive=1011: rotation runs 0 -> 1 -> 3 -> 0 (index 2 skipped), with wrap verified.
- TIMEOUT_CYCLES=5, no requests: turn_timeout pulses 5 cycles after fire_en rises, then the next player has fire_en. A request on the expiry edge yields a grant and no timeout.
- alive drops to 0001 during RESOLVE: after shot_done, game_over=1, fire_en=0. state->0 returns the FSM to IDLE.
- state changes 3->4 during TURN: fire_en and taking_turns are 0 next cycle, with no grant. Returning to 3 restarts from the lowest alive player.
- fire_req[1] while p0 is active -> no grant. Reset asserted in RESOLVE -> all outputs 0 immediately.
